// File: rtl/pipeio_pkg.sv
// Shared constants for the pipelined-CPU memory-mapped I/O port.
// Word offsets are addr[7:2]; the I/O region is selected by addr[IO_SEL_BIT].
package pipeio_pkg;

    localparam int unsigned IO_SEL_BIT       = 7;
    localparam int unsigned DEBOUNCE_DEFAULT = 4;

    // Word offsets (byte address >> 2)
    localparam logic [5:0] IO_IN0    = 6'h20;  // 0x80
    localparam logic [5:0] IO_IN1    = 6'h21;  // 0x84
    localparam logic [5:0] IO_STATUS = 6'h22;  // 0x88
    localparam logic [5:0] IO_OUT0   = 6'h30;  // 0xC0
    localparam logic [5:0] IO_OUT1   = 6'h31;  // 0xC4
    localparam logic [5:0] IO_OUT2   = 6'h32;  // 0xC8
    localparam logic [5:0] IO_OUT3   = 6'h33;  // 0xCC
    localparam logic [5:0] IO_OUT4   = 6'h34;  // 0xD0
    localparam logic [5:0] IO_OUT5   = 6'h35;  // 0xD4

    // Debounce counter width: ceil(log2(n)), never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pipeio_if.sv
// MEM-stage data bus between the CPU (master) and the I/O responder (slave).
//   we      store strobe          addr    byte address
//   datain  store data            io_sel  address is in the I/O region
//   dataout load data for I/O addresses
interface pipeio_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        io_sel;
    logic [31:0] dataout;

    modport master (output we, output addr, output datain, input io_sel, input dataout);
    modport slave  (input we, input addr, input datain, output io_sel, output dataout);
endinterface

// File: rtl/io_debounce.sv
// Two-flop synchroniser plus debouncer for one input port.
//   clock, resetn  clock and async active-low reset
//   pin_i          raw asynchronous input vector
//   deb_o          debounced value
//   accept_o       high in the cycle whose closing edge loads a new debounced value
// The whole vector is one value: it is accepted once the synchronised input
// has differed from deb for DEBOUNCE_CYCLES consecutive edges, even if it
// changes to another non-deb value along the way.
module io_debounce
    import pipeio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned IN_W            = 4
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [IN_W-1:0] pin_i,
    output logic [IN_W-1:0] deb_o,
    output logic            accept_o
);

    localparam int unsigned    CntW    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [IN_W-1:0] s1_q, s2_q, deb_q, deb_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d    = deb_q;
        cnt_d    = cnt_q;
        accept_o = 1'b0;
        if (s2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            deb_d    = s2_q;
            cnt_d    = '0;
            accept_o = 1'b1;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_q  <= '0;
            s2_q  <= '0;
            deb_q <= '0;
            cnt_q <= '0;
        end else begin
            s1_q  <= pin_i;
            s2_q  <= s1_q;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/pipeio_port.sv
// Memory-mapped I/O responder on the MEM-stage data bus.
//   clock, resetn          clock and async active-low reset
//   bus                    CPU load/store bus (slave side), zero-latency reads
//   in_port0, in_port1     raw switch inputs, synchronised and debounced
//   out_port0..out_port5   software-written output registers
//   irq                    OR of the two input-change flags
module pipeio_port
    import pipeio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned IN_W            = 4
) (
    input  logic            clock,
    input  logic            resetn,
    pipeio_if.slave         bus,
    input  logic [IN_W-1:0] in_port0,
    input  logic [IN_W-1:0] in_port1,
    output logic [31:0]     out_port0,
    output logic [31:0]     out_port1,
    output logic [31:0]     out_port2,
    output logic [31:0]     out_port3,
    output logic [31:0]     out_port4,
    output logic [31:0]     out_port5,
    output logic            irq
);

    logic [IN_W-1:0] deb0, deb1;
    logic            acc0, acc1;
    logic [5:0]      off;
    logic            wr;
    logic [31:0]     out_q [6];
    logic [31:0]     out_d [6];
    logic [1:0]      chg_q, chg_d;
    logic            unused_addr;

    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IN_W(IN_W)) u_deb0 (
        .clock    (clock),
        .resetn   (resetn),
        .pin_i    (in_port0),
        .deb_o    (deb0),
        .accept_o (acc0)
    );

    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IN_W(IN_W)) u_deb1 (
        .clock    (clock),
        .resetn   (resetn),
        .pin_i    (in_port1),
        .deb_o    (deb1),
        .accept_o (acc1)
    );

    assign unused_addr = ^{bus.addr[31:8], bus.addr[1:0]};
    assign off         = bus.addr[IO_SEL_BIT:2];
    assign bus.io_sel  = bus.addr[IO_SEL_BIT];
    assign wr          = bus.we & bus.io_sel;

    always_comb begin
        out_d = out_q;
        if (wr) begin
            case (off)
                IO_OUT0: out_d[0] = bus.datain;
                IO_OUT1: out_d[1] = bus.datain;
                IO_OUT2: out_d[2] = bus.datain;
                IO_OUT3: out_d[3] = bus.datain;
                IO_OUT4: out_d[4] = bus.datain;
                IO_OUT5: out_d[5] = bus.datain;
                default: ;
            endcase
        end
    end

    // Clear first, then set, so an acceptance on the same edge keeps its flag.
    always_comb begin
        chg_d = chg_q;
        if (wr && off == IO_STATUS) begin
            chg_d = chg_d & ~bus.datain[1:0];
        end
        chg_d = chg_d | {acc1, acc0};
    end

    always_comb begin
        bus.dataout = '0;
        if (bus.io_sel) begin
            case (off)
                IO_IN0:    bus.dataout = 32'(deb0);
                IO_IN1:    bus.dataout = 32'(deb1);
                IO_STATUS: bus.dataout = {30'b0, chg_q};
                IO_OUT0:   bus.dataout = out_q[0];
                IO_OUT1:   bus.dataout = out_q[1];
                IO_OUT2:   bus.dataout = out_q[2];
                IO_OUT3:   bus.dataout = out_q[3];
                IO_OUT4:   bus.dataout = out_q[4];
                IO_OUT5:   bus.dataout = out_q[5];
                default:   bus.dataout = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < 6; k++) out_q[k] <= '0;
            chg_q <= '0;
        end else begin
            out_q <= out_d;
            chg_q <= chg_d;
        end
    end

    assign out_port0 = out_q[0];
    assign out_port1 = out_q[1];
    assign out_port2 = out_q[2];
    assign out_port3 = out_q[3];
    assign out_port4 = out_q[4];
    assign out_port5 = out_q[5];
    assign irq       = |chg_q;

endmodule
